// File: rtl/board_io_pkg.sv
// Shared constants for the board's pushbutton/switch front end.
package board_io_pkg;

    localparam logic        KEY_ACTIVE_LEVEL      = 1'b0;
    localparam int unsigned DEBOUNCE_1MS_50MHZ    = 50000;
    localparam int unsigned REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int unsigned REPEAT_PERIOD_DEFAULT = 5000000;
    localparam int unsigned SIM_DEBOUNCE_CYCLES   = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One-bit conditioner: 2-flop synchroniser, stability counter, debounced level and
// registered rise/fall strobes. RESET_VAL seeds both the synchroniser and the level.
module debounce_cell
    import board_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CW   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          stable_q, stable_d;
    logic          rise_q, rise_d, fall_q, fall_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Counter only runs while the sample disagrees with the accepted level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + 1'b1;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == TERM) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            rise_d   = sync2_q;
            fall_d   = ~sync2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= RESET_VAL;
            sync2_q  <= RESET_VAL;
            stable_q <= RESET_VAL;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= d_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;

endmodule

// File: rtl/key_conditioner.sv
// Pushbutton/switch front end: debounced levels plus press/release/change strobes.
// Optional key auto-repeat is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 2,
    parameter int unsigned SW_W            = 16,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_1MS_50MHZ,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic [SW_W-1:0]     sw_raw,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [SW_W-1:0]     sw_stable,
    output logic                sw_change
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [NUM_KEYS-1:0] key_stable, key_rise, key_fall, key_press_ev;
    logic [SW_W-1:0]     sw_rise, sw_fall;

    // Key cells work on the raw pin polarity so their reset value is "released".
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (~KEY_ACTIVE_LEVEL)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .d_i      (key_n[i]),
            .stable_o (key_stable[i]),
            .rise_o   (key_rise[i]),
            .fall_o   (key_fall[i])
        );
        assign key_level[i]    = (key_stable[i] == KEY_ACTIVE_LEVEL);
        assign key_press_ev[i] = KEY_ACTIVE_LEVEL ? key_rise[i] : key_fall[i];
        assign key_release[i]  = KEY_ACTIVE_LEVEL ? key_fall[i] : key_rise[i];
    end

    for (genvar i = 0; i < SW_W; i++) begin : g_sw
        debounce_cell #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (1'b0)
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .d_i      (sw_raw[i]),
            .stable_o (sw_stable[i]),
            .rise_o   (sw_rise[i]),
            .fall_o   (sw_fall[i])
        );
    end

    assign sw_change = |(sw_rise | sw_fall);

`ifdef KEY_AUTOREPEAT_EN
    localparam int unsigned      REP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned      REP_W       = cnt_width(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_TERM  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_TERM = REP_W'(REPEAT_PERIOD - 1);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_rep
        logic [REP_W-1:0] cnt_q, cnt_d;
        logic             first_q, first_d;
        logic             pulse_q, pulse_d;

        // Counter restarts from zero on every accepted press and after each repeat.
        always_comb begin
            cnt_d   = cnt_q + 1'b1;
            first_d = first_q;
            pulse_d = 1'b0;
            if (!key_level[i]) begin
                cnt_d   = '0;
                first_d = 1'b1;
            end else if (cnt_q == (first_q ? DELAY_TERM : PERIOD_TERM)) begin
                cnt_d   = '0;
                first_d = 1'b0;
                pulse_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                first_q <= 1'b1;
                pulse_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                first_q <= first_d;
                pulse_q <= pulse_d;
            end
        end

        assign key_press[i] = key_press_ev[i] | pulse_q;
    end
`else
    assign key_press = key_press_ev;
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus drives a window-based reference model,
// a negedge monitor matches DUT strobes and level checkpoints against queued expectations.
module tb_key_conditioner;
    import board_io_pkg::*;

    localparam int unsigned D    = SIM_DEBOUNCE_CYCLES;
    localparam int unsigned RD   = 20;
    localparam int unsigned RP   = 8;
    localparam int unsigned MAXC = 4096;
    localparam logic [17:0] RST_VEC = {16'h0000, 2'b11};

    typedef struct {
        int unsigned cyc;
        logic [1:0]  press;
        logic [1:0]  rel;
        logic        chg;
        logic [1:0]  lvl;
        logic [15:0] sw;
    } ev_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  lvl;
        logic [15:0] sw;
    } cp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  key_n;
    logic [15:0] sw_raw;
    logic [1:0]  key_level, key_press, key_release;
    logic [15:0] sw_stable;
    logic        sw_change;

    key_conditioner #(
        .NUM_KEYS        (2),
        .SW_W            (16),
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_stable   (sw_stable),
        .sw_change   (sw_change)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t evq[$];
    cp_t cpq[$];
    bit  done = 1'b0;

    // Reference model: raw-pin history per edge; a bit's level flips once the last D
    // synchronised samples (two edges old) all disagree with it.
    logic [17:0] hist [MAXC];
    logic [17:0] mst;
    int unsigned acc_edge [2];

    task automatic model_edge();
        int unsigned k;
        int unsigned dt;
        logic [17:0] nxt;
        logic [1:0]  press, rel;
        logic        chg;
        bit          all_diff;
        k = cyc;
        if (rst) begin
            hist[k]   = RST_VEC;
            hist[k-1] = RST_VEC;
            mst       = RST_VEC;
            return;
        end
        hist[k] = {sw_raw, key_n};
        nxt = mst;
        if (k >= D + 1) begin
            for (int b = 0; b < 18; b++) begin
                all_diff = 1'b1;
                for (int j = 0; j < int'(D); j++)
                    if (hist[k-2-j][b] == mst[b]) all_diff = 1'b0;
                if (all_diff) nxt[b] = ~mst[b];
            end
        end
        press = mst[1:0] & ~nxt[1:0];
        rel   = ~mst[1:0] & nxt[1:0];
        chg   = |(mst[17:2] ^ nxt[17:2]);
`ifdef KEY_AUTOREPEAT_EN
        for (int i = 0; i < 2; i++) begin
            if (!mst[i] && k > acc_edge[i]) begin
                dt = k - acc_edge[i];
                if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) press[i] = 1'b1;
            end
        end
`else
        dt = 0;
`endif
        for (int i = 0; i < 2; i++)
            if (mst[i] && !nxt[i]) acc_edge[i] = k;
        mst = nxt;
        if ((press | rel) != 2'b00 || chg)
            evq.push_back('{k, press, rel, chg, ~nxt[1:0], nxt[17:2]});
    endtask

    task automatic step(input logic [1:0] kn, input logic [15:0] sv, input logic r);
        // An async reset wipes a strobe registered on the edge just passed.
        if (r && !rst && evq.size() > 0 && evq[$].cyc == cyc) void'(evq.pop_back());
        key_n  = kn;
        sw_raw = sv;
        rst    = r;
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic hold(input logic [1:0] kn, input logic [15:0] sv, input int n);
        repeat (n) step(kn, sv, 1'b0);
    endtask

    task automatic checkpoint();
        cpq.push_back('{cyc, ~mst[1:0], mst[17:2]});
    endtask

    initial begin
        logic [1:0]  kn;
        logic [15:0] sv;
        for (int i = 0; i < int'(MAXC); i++) hist[i] = RST_VEC;
        mst = RST_VEC;
        acc_edge[0] = 0;
        acc_edge[1] = 0;
        rst    = 1'b1;
        key_n  = 2'b00;
        sw_raw = 16'hFFFF;

        repeat (4) step(2'b00, 16'hFFFF, 1'b1);
        hold(2'b00, 16'hFFFF, 12); checkpoint();
        hold(2'b11, 16'hFFFF, 12); checkpoint();

        hold(2'b01, 16'hFFFF, 20); checkpoint();
        hold(2'b11, 16'hFFFF, 12); checkpoint();

        for (int t = 0; t < 30; t++) step({1'b1, ((t / 2) % 2 == 0) ? 1'b0 : 1'b1}, 16'hFFFF, 1'b0);
        hold(2'b10, 16'hFFFF, 12); checkpoint();
        hold(2'b11, 16'hFFFF, 12); checkpoint();

        hold(2'b11, 16'h0000, 12); checkpoint();
        hold(2'b11, 16'h12AB, 12); checkpoint();
        hold(2'b11, 16'h12AA, 3);
        hold(2'b11, 16'h12AB, 12); checkpoint();
        hold(2'b11, 16'h12AA, 4);
        hold(2'b11, 16'h12AB, 12); checkpoint();

        hold(2'b10, 16'h12AB, 4);
        step(2'b11, 16'h12AB, 1'b1);
        step(2'b11, 16'h12AB, 1'b1);
        hold(2'b11, 16'h12AB, 12); checkpoint();

        hold(2'b01, 16'h12AB, 50); checkpoint();
        hold(2'b11, 16'h12AB, 12); checkpoint();

        hold(2'b00, 16'h12AB, 10);
        hold(2'b11, 16'h12AB, 10); checkpoint();

        kn = 2'b11;
        sv = 16'h12AB;
        repeat (800) begin
            if ($urandom_range(0, 5) == 0) kn[$urandom_range(0, 1)] ^= 1'b1;
            if ($urandom_range(0, 7) == 0) sv[$urandom_range(0, 15)] ^= 1'b1;
            step(kn, sv, ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
        end
        hold(kn, sv, 12); checkpoint();
        hold(kn, sv, 4);
        done = 1'b1;
    end

    int  n_chk  = 0;
    int  n_fail = 0;
    ev_t e;
    cp_t c;

    always @(negedge clk) begin
        if (rst) begin
            n_chk++;
            if ({key_level, key_press, key_release, sw_stable, sw_change} != '0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got lvl=%b press=%b rel=%b sw=%h chg=%b required all zero",
                         cyc, key_level, key_press, key_release, sw_stable, sw_change);
            end
        end else begin
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                e = evq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL missed_strobe cyc=%0d got none required press=%b rel=%b chg=%b",
                         e.cyc, e.press, e.rel, e.chg);
            end
            if ((key_press | key_release) != 2'b00 || sw_change) begin
                n_chk++;
                if (evq.size() > 0 && evq[0].cyc == cyc) begin
                    e = evq.pop_front();
                    if (key_press !== e.press || key_release !== e.rel || sw_change !== e.chg ||
                        key_level !== e.lvl || sw_stable !== e.sw) begin
                        n_fail++;
                        $display("FAIL strobe cyc=%0d got press=%b rel=%b chg=%b lvl=%b sw=%h required press=%b rel=%b chg=%b lvl=%b sw=%h",
                                 cyc, key_press, key_release, sw_change, key_level, sw_stable,
                                 e.press, e.rel, e.chg, e.lvl, e.sw);
                    end
                end else begin
                    n_fail++;
                    $display("FAIL unexpected_strobe cyc=%0d got press=%b rel=%b chg=%b required none",
                             cyc, key_press, key_release, sw_change);
                end
            end
            while (cpq.size() > 0 && cpq[0].cyc <= cyc) begin
                c = cpq.pop_front();
                n_chk++;
                if (c.cyc != cyc || key_level !== c.lvl || sw_stable !== c.sw) begin
                    n_fail++;
                    $display("FAIL level_checkpoint cyc=%0d got lvl=%b sw=%h required lvl=%b sw=%h",
                             cyc, key_level, sw_stable, c.lvl, c.sw);
                end
            end
        end
        if (done) begin
            n_chk++;
            if (evq.size() != 0 || cpq.size() != 0) begin
                n_fail++;
                $display("FAIL drain got %0d strobes and %0d checkpoints pending required 0",
                         evq.size(), cpq.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
            $finish;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got done=%0b required 1 before time limit", done);
        $fatal(1, "time limit reached");
    end

endmodule
